// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage core: opcodes, memory-stage state and
// writeback bundle.
package mips_pkg;

    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_BLT  = 6'b010110;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_NOPE = 6'b111111;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Writeback control fields; the data word travels beside it because its
    // width is a module parameter.
    typedef struct packed {
        logic       en;
        logic [5:0] opcode;
        logic [5:0] rd;
    } wb_bundle_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/ack FSM: latches the access, holds the request and,
// when MEM_TIMEOUT_EN is defined, aborts an access that never gets an ack.
module dmem_handshake
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_op_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              abort_o,
    output logic              stall_o,
    output logic              req_o,
    output logic              we_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dmem_handshake: TIMEOUT must be at least 1");
    end

    mem_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              expire;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is 0 in the first request cycle, so expiry lands on the
    // TIMEOUT-th cycle of the request.
    assign expire = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_o  = 1'b0;
        abort_o = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_i) begin
                    stall_o = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Ack wins over a simultaneous expiry.
                stall_o = !(ack_i || expire);
                if (ack_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end else if (expire) begin
                    abort_o = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o  = (state_q == ACCESS);
    assign req_o   = busy_o;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: issues LDW/STW over the dmem handshake and
// registers the writeback bundle. Optional access timeout via MEM_TIMEOUT_EN.
module memory_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_46,
    input  logic              rst_46,
    input  logic [5:0]        opcode_46,
    input  logic [DATA_W-1:0] alu_out_46,
    input  logic [DATA_W-1:0] alu_src_46,
    input  logic [5:0]        dest_reg_46,
    input  logic [5:0]        targ_reg_46,
    output logic              stall_46,
    output logic              dmem_req_46,
    output logic              dmem_we_46,
    output logic [DATA_W-1:0] dmem_addr_46,
    output logic [DATA_W-1:0] dmem_wdata_46,
    input  logic              dmem_ack_46,
    input  logic [DATA_W-1:0] dmem_rdata_46,
    output logic              wb_en_46,
    output logic [5:0]        wb_opcode_46,
    output logic [5:0]        wb_reg_46,
    output logic [DATA_W-1:0] wb_data_46,
    output logic              err_46
);

    logic              mem_op;
    logic              busy, done, abort;
    logic [5:0]        op_q, op_d;
    logic [5:0]        targ_q, targ_d;
    wb_bundle_t        wb_q, wb_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    assign mem_op = is_mem_op(opcode_46);

    dmem_handshake #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk_i   (clk_46),
        .rst_i   (rst_46),
        .mem_op_i(mem_op),
        .we_i    (opcode_46 == OP_STW),
        .addr_i  (alu_out_46),
        .wdata_i (alu_src_46),
        .ack_i   (dmem_ack_46),
        .busy_o  (busy),
        .done_o  (done),
        .abort_o (abort),
        .stall_o (stall_46),
        .req_o   (dmem_req_46),
        .we_o    (dmem_we_46),
        .addr_o  (dmem_addr_46),
        .wdata_o (dmem_wdata_46)
    );

    // A bubble (all zero) is registered whenever nothing retires this cycle.
    always_comb begin
        op_d      = op_q;
        targ_d    = targ_q;
        wb_d      = '0;
        wb_data_d = '0;
        if (!busy) begin
            if (mem_op) begin
                op_d   = opcode_46;
                targ_d = targ_reg_46;
            end else begin
                wb_d.opcode = opcode_46;
                case (opcode_46)
                    OP_ADD, OP_MUL: begin
                        wb_d.en   = 1'b1;
                        wb_d.rd   = dest_reg_46;
                        wb_data_d = alu_out_46;
                    end
                    OP_ADDI: begin
                        wb_d.en   = 1'b1;
                        wb_d.rd   = targ_reg_46;
                        wb_data_d = alu_out_46;
                    end
                    default: ;
                endcase
            end
        end else if (done) begin
            wb_d.opcode = op_q;
            if (op_q == OP_LDW) begin
                wb_d.en   = 1'b1;
                wb_d.rd   = targ_q;
                wb_data_d = dmem_rdata_46;
            end
        end else if (abort) begin
            wb_d.opcode = op_q;
        end
    end

    always_ff @(posedge clk_46) begin
        op_q   <= op_d;
        targ_q <= targ_d;
    end

    always_ff @(posedge clk_46) begin
        if (rst_46) begin
            wb_q      <= '0;
            wb_data_q <= '0;
        end else begin
            wb_q      <= wb_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en_46     = wb_q.en;
    assign wb_opcode_46 = wb_q.opcode;
    assign wb_reg_46    = wb_q.rd;
    assign wb_data_46   = wb_data_q;

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk_46) begin
        if (rst_46) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign err_46 = err_q;
`else
    assign err_46 = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writebacks are queued at issue
// and retired by a negedge monitor; scenario tasks check handshake timing.
module tb_memory_stage;
    import mips_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk_46 = 1'b0;
    logic        rst_46;
    logic [5:0]  opcode_46, dest_reg_46, targ_reg_46;
    logic [31:0] alu_out_46, alu_src_46, dmem_rdata_46;
    logic        dmem_ack_46;
    logic        stall_46, dmem_req_46, dmem_we_46, wb_en_46, err_46;
    logic [31:0] dmem_addr_46, dmem_wdata_46, wb_data_46;
    logic [5:0]  wb_opcode_46, wb_reg_46;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles = 0;
    int req_edges  = 0;
    logic req_prev = 1'b0;

    typedef struct packed {
        logic        en;
        logic [5:0]  op;
        logic [5:0]  rg;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    always #5 clk_46 = ~clk_46;

    memory_stage #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_46(clk_46), .rst_46(rst_46), .opcode_46(opcode_46),
        .alu_out_46(alu_out_46), .alu_src_46(alu_src_46),
        .dest_reg_46(dest_reg_46), .targ_reg_46(targ_reg_46),
        .stall_46(stall_46), .dmem_req_46(dmem_req_46), .dmem_we_46(dmem_we_46),
        .dmem_addr_46(dmem_addr_46), .dmem_wdata_46(dmem_wdata_46),
        .dmem_ack_46(dmem_ack_46), .dmem_rdata_46(dmem_rdata_46),
        .wb_en_46(wb_en_46), .wb_opcode_46(wb_opcode_46), .wb_reg_46(wb_reg_46),
        .wb_data_46(wb_data_46), .err_46(err_46)
    );

    // Retire monitor: a non-zero forwarded opcode is one retired instruction.
    always @(negedge clk_46) begin : mon
        exp_t e;
        if (dmem_req_46 === 1'b1) req_cycles++;
        if (dmem_req_46 === 1'b1 && req_prev !== 1'b1) req_edges++;
        req_prev = dmem_req_46;
        if (wb_opcode_46 !== 6'd0) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got op=%h en=%b reg=%0d data=%h, required no writeback",
                         wb_opcode_46, wb_en_46, wb_reg_46, wb_data_46);
            end else begin
                e = sbq.pop_front();
                if (wb_en_46 !== e.en || wb_opcode_46 !== e.op ||
                    (e.en && (wb_reg_46 !== e.rg || wb_data_46 !== e.data))) begin
                    n_fail++;
                    $display("FAIL sb_wb: got en=%b op=%h reg=%0d data=%h, required en=%b op=%h reg=%0d data=%h",
                             wb_en_46, wb_opcode_46, wb_reg_46, wb_data_46, e.en, e.op, e.rg, e.data);
                end
            end
        end else begin
            n_tests++;
            if (wb_en_46 !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_bubble_en: got wb_en=%b with opcode 0, required 0", wb_en_46);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_46);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] src,
                           input logic [5:0] dest, input logic [5:0] targ);
        opcode_46   = op;
        alu_out_46  = alu;
        alu_src_46  = src;
        dest_reg_46 = dest;
        targ_reg_46 = targ;
    endtask

    task automatic mem_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [5:0] targ, input int k, input logic [31:0] rdata,
                              input logic [5:0] nop, input logic [31:0] nalu, input logic [5:0] ntarg);
        exp_t e;
        int   stalls;
        e.en = (op == OP_LDW); e.op = op; e.rg = targ; e.data = rdata;
        sbq.push_back(e);
        present(op, addr, wdata, 6'd1, targ);
        dmem_ack_46 = 1'b0;
        #1;
        n_tests++;
        if (stall_46 !== 1'b1 || dmem_req_46 !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_issue: got stall=%b req=%b, required stall=1 req=0", stall_46, dmem_req_46);
        end
        stalls = (stall_46 === 1'b1) ? 1 : 0;
        for (int c = 1; c <= k; c++) begin
            tick();
            dmem_ack_46   = (c == k);
            dmem_rdata_46 = (c == k) ? rdata : (32'hBAD0_0000 | c);
            #1;
            n_tests++;
            if (dmem_req_46 !== 1'b1 || dmem_we_46 !== (op == OP_STW) ||
                dmem_addr_46 !== addr || dmem_wdata_46 !== wdata) begin
                n_fail++;
                $display("FAIL mem_hold c=%0d: got req=%b we=%b addr=%h wdata=%h, required req=1 we=%b addr=%h wdata=%h",
                         c, dmem_req_46, dmem_we_46, dmem_addr_46, dmem_wdata_46, op == OP_STW, addr, wdata);
            end
            if (stall_46 === 1'b1) stalls++;
        end
        tick();
        dmem_ack_46 = 1'b0;
        present(nop, nalu, wdata, 6'd0, ntarg);
        #1;
        n_tests++;
        if (dmem_req_46 !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_release: got req=%b, required 0", dmem_req_46);
        end
        n_tests++;
        if (stalls != k) begin
            n_fail++;
            $display("FAIL mem_stall_cycles: got %0d, required %0d", stalls, k);
        end
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending writebacks, required 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst_46 = 1'b1;
        present(6'd0, 32'h0, 32'h0, 6'd0, 6'd0);
        dmem_ack_46 = 1'b0; dmem_rdata_46 = 32'h0;
        tick();
        tick();
        n_tests++;
        if ({stall_46, dmem_req_46, dmem_we_46, dmem_addr_46, dmem_wdata_46,
             wb_en_46, wb_opcode_46, wb_reg_46, wb_data_46, err_46} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b req=%b wb_en=%b wb_op=%h err=%b, required all 0",
                     stall_46, dmem_req_46, wb_en_46, wb_opcode_46, err_46);
        end
        rst_46 = 1'b0;
        tick();
    endtask

    task automatic test_alu_ops();
        logic [5:0]  ops [8] = '{OP_ADD, OP_MUL, OP_ADDI, OP_BEQ, OP_BR, OP_NOPE, OP_BLT, 6'h2A};
        logic [31:0] alus[8] = '{32'h15, 32'hABCD, 32'h9, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            present(ops[i], alus[i], 32'hFFFF_0000, 6'd3 + 6'(i), 6'd7 + 6'(i));
            dmem_ack_46   = i[0];
            dmem_rdata_46 = $urandom;
            e.op   = ops[i];
            e.en   = (ops[i] == OP_ADD) || (ops[i] == OP_MUL) || (ops[i] == OP_ADDI);
            e.rg   = (ops[i] == OP_ADDI) ? 6'd7 + 6'(i) : 6'd3 + 6'(i);
            e.data = alus[i];
            sbq.push_back(e);
            #1;
            n_tests++;
            if (stall_46 !== 1'b0 || dmem_req_46 !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_no_stall op=%h: got stall=%b req=%b, required 0 0", ops[i], stall_46, dmem_req_46);
            end
            tick();
        end
        present(6'd0, 32'h0, 32'h0, 6'd0, 6'd0);
        dmem_ack_46 = 1'b0;
        drain("alu");
    endtask

    task automatic test_ldw();
        int r0;
        r0 = req_cycles;
        mem_access(OP_LDW, 32'h40, 32'h0, 6'd5, 3, 32'hDEAD_BEEF, 6'd0, 32'h0, 6'd0);
        drain("ldw");
        n_tests++;
        if (req_cycles - r0 != 3) begin
            n_fail++;
            $display("FAIL ldw_req_cycles: got %0d, required 3", req_cycles - r0);
        end
    endtask

    task automatic test_stw();
        int r0;
        r0 = req_cycles;
        mem_access(OP_STW, 32'h44, 32'h1234, 6'd0, 1, 32'h0, 6'd0, 32'h0, 6'd0);
        drain("stw");
        n_tests++;
        if (req_cycles - r0 != 1) begin
            n_fail++;
            $display("FAIL stw_req_cycles: got %0d, required 1", req_cycles - r0);
        end
    endtask

    task automatic test_back_to_back();
        int   e0;
        exp_t e;
        e0 = req_edges;
        mem_access(OP_LDW, 32'h300, 32'h0, 6'd5, 1, 32'h1111_2222, OP_ADDI, 32'h9, 6'd7);
        e.en = 1'b1; e.op = OP_ADDI; e.rg = 6'd7; e.data = 32'h9;
        sbq.push_back(e);
        tick();
        n_tests++;
        if (req_edges - e0 != 1) begin
            n_fail++;
            $display("FAIL b2b_ldw_addi_reqs: got %0d, required 1", req_edges - e0);
        end
        mem_access(OP_LDW, 32'h310, 32'h0, 6'd10, 2, 32'hA5A5_0001, OP_STW, 32'h314, 6'd0);
        mem_access(OP_STW, 32'h314, 32'h77, 6'd0, 1, 32'h0, 6'd0, 32'h0, 6'd0);
        drain("b2b");
        n_tests++;
        if (req_edges - e0 != 3) begin
            n_fail++;
            $display("FAIL b2b_total_reqs: got %0d, required 3", req_edges - e0);
        end
    endtask

    task automatic test_reset_in_access();
        present(OP_LDW, 32'h80, 32'h0, 6'd1, 6'd6);
        dmem_ack_46 = 1'b0;
        tick();
        tick();
        rst_46 = 1'b1;
        present(6'd0, 32'h0, 32'h0, 6'd0, 6'd0);
        tick();
        rst_46 = 1'b0;
        dmem_ack_46 = 1'b1;
        dmem_rdata_46 = 32'h5555_AAAA;
        #1;
        n_tests++;
        if ({stall_46, dmem_req_46, dmem_we_46, dmem_addr_46, dmem_wdata_46,
             wb_en_46, wb_opcode_46, wb_reg_46, wb_data_46, err_46} !== '0) begin
            n_fail++;
            $display("FAIL rst_access_outputs: got stall=%b req=%b addr=%h wb_en=%b, required all 0",
                     stall_46, dmem_req_46, dmem_addr_46, wb_en_46);
        end
        tick();
        dmem_ack_46 = 1'b0;
        n_tests++;
        if (dmem_req_46 !== 1'b0 || wb_en_46 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_late_ack: got req=%b wb_en=%b, required 0 0", dmem_req_46, wb_en_46);
        end
        drain("rst_access");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        e.en = 1'b0; e.op = OP_LDW; e.rg = 6'd2; e.data = 32'h0;
        sbq.push_back(e);
        present(OP_LDW, 32'h100, 32'h0, 6'd1, 6'd2);
        dmem_ack_46 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            #1;
            n_tests++;
            if (dmem_req_46 !== 1'b1 || stall_46 !== (c < 4) || err_46 !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait c=%0d: got req=%b stall=%b err=%b, required req=1 stall=%b err=0",
                         c, dmem_req_46, stall_46, err_46, c < 4);
            end
        end
        tick();
        present(6'd0, 32'h0, 32'h0, 6'd0, 6'd0);
        n_tests++;
        if (dmem_req_46 !== 1'b0 || err_46 !== 1'b1 || wb_en_46 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got req=%b err=%b wb_en=%b, required 0 1 0",
                     dmem_req_46, err_46, wb_en_46);
        end
        tick();
        n_tests++;
        if (err_46 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_pulse: got err=%b, required 0", err_46);
        end
        drain("timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_ldw();
        test_stw();
        test_back_to_back();
        test_reset_in_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
